cp0_irq_ctrl: RTL and testbench

- Sequential CP0 exception/interrupt controller for the single-cycle MIPS core.
- Sits beside the instruction decoder. Holds the Status, Cause and EPC registers and latches N_IRQ edge-triggered external interrupt lines.
- Prioritises synchronous exceptions over interrupts and interrupts among themselves.
- Supports nested handlers through a parametrised interrupt-enable stack, and drives the PC-select, acknowledge and mfc0 read data.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0_irq_ctrl_if.sv | 30 +++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/cp0_irq_ctrl.sv | 142 ++++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions, PC-select codes.
package cp0_pkg;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam logic [3:0] EXC_INT    = 4'd0;
   localparam logic [3:0] EXC_SYS    = 4'd1;
   localparam logic [3:0] EXC_UNIMPL = 4'd2;
   localparam logic [3:0] EXC_OV     = 4'd3;

   localparam int ST_EN_SYS    = 1;
   localparam int ST_EN_UNIMPL = 2;
   localparam int ST_EN_OV     = 3;
   localparam int ST_MASK_LSB  = 8;
   localparam int ST_IE_LSB    = 16;

   localparam int CA_EXC_LSB  = 2;
   localparam int CA_PEND_LSB = 8;
   localparam int CA_IDX_LSB  = 16;

   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      SELPC_SEQ     = 2'b00,
      SELPC_EPC     = 2'b01,
      SELPC_HANDLER = 2'b10
   } selpc_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Decoder/datapath-facing bundle of the CP0 controller.
interface cp0_irq_ctrl_if #(parameter int N_IRQ = 4);

   logic [N_IRQ-1:0] irq;
   logic             i_syscall;
   logic             i_unimpl;
   logic             ov_event;
   logic             i_mtc0;
   logic             i_mfc0;
   logic             i_eret;
   logic [4:0]       rd;
   logic [31:0]      wdata;
   logic [31:0]      pc;
   logic             exc;
   logic [1:0]       selpc;
   logic [N_IRQ-1:0] inta;
   logic [31:0]      epc;
   logic [31:0]      rdata;

   modport master (
      output irq, i_syscall, i_unimpl, ov_event, i_mtc0, i_mfc0, i_eret, rd, wdata, pc,
      input  exc, selpc, inta, epc, rdata
   );

   modport slave (
      input  irq, i_syscall, i_unimpl, ov_event, i_mtc0, i_mfc0, i_eret, rd, wdata, pc,
      output exc, selpc, inta, epc, rdata
   );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the masked pending interrupt vector.
module irq_prio_enc
   import cp0_pkg::*;
#(
   parameter int N_IRQ = 4
) (
   input  logic [N_IRQ-1:0] i_req,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx,
   output logic [N_IRQ-1:0] o_onehot
);

   logic [N_IRQ-1:0] w_onehot;

   // Isolate the lowest set request bit (two's-complement trick).
   assign w_onehot = i_req & (~i_req + N_IRQ'(1));
   assign o_valid  = |i_req;
   assign o_onehot = w_onehot;

   // Binary index of the one-hot winner.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         o_idx = o_idx | (w_onehot[i] ? IDX_W'(i) : '0);
      end
   end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 Status/Cause/EPC with edge-captured interrupts, exception priority and nesting IE stack.
module cp0_irq_ctrl
   import cp0_pkg::*;
#(
   parameter int N_IRQ       = 4,
   parameter int STACK_DEPTH = 3
) (
   input  logic           Clk,
   input  logic           Clrn,
   cp0_irq_ctrl_if.slave  bus
);

   logic [N_IRQ-1:0]       r_irq_q;
   logic [N_IRQ-1:0]       r_pending;
   logic [3:1]             r_en;
   logic [N_IRQ-1:0]       r_mask;
   logic [STACK_DEPTH-1:0] r_ie_stk;
   logic [3:0]             r_exccode;
   logic [IDX_W-1:0]       r_irq_idx;
   logic [31:0]            r_epc;

   logic [N_IRQ-1:0]       w_rise;
   logic [N_IRQ-1:0]       w_masked;
   logic                   w_irq_valid;
   logic [IDX_W-1:0]       w_irq_idx;
   logic [N_IRQ-1:0]       w_irq_onehot;
   logic                   w_unimpl;
   logic                   w_sys;
   logic                   w_ov;
   logic                   w_sync;
   logic                   w_int_take;
   logic                   w_take;
   logic [3:0]             w_exccode;
   logic                   w_mtc0_wr;
   logic [N_IRQ-1:0]       w_pend_clr;
   logic [N_IRQ-1:0]       w_pend_nxt;
   logic [STACK_DEPTH-1:0] w_stk_push;
   logic [STACK_DEPTH-1:0] w_stk_pop;
   logic [31:0]            w_status;
   logic [31:0]            w_cause;
   logic [31:0]            w_rdata;

   irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
      .i_req    (w_masked),
      .o_valid  (w_irq_valid),
      .o_idx    (w_irq_idx),
      .o_onehot (w_irq_onehot)
   );

   assign w_rise     = bus.irq & ~r_irq_q;
   assign w_masked   = r_pending & r_mask;
   assign w_unimpl   = bus.i_unimpl  & r_en[ST_EN_UNIMPL];
   assign w_sys      = bus.i_syscall & r_en[ST_EN_SYS];
   assign w_ov       = bus.ov_event  & r_en[ST_EN_OV];
   assign w_sync     = w_unimpl | w_sys | w_ov;
   assign w_int_take = ~w_sync & w_irq_valid & r_ie_stk[0] & ~bus.i_eret;
   assign w_take     = w_sync | w_int_take;
   assign w_mtc0_wr  = bus.i_mtc0 & ~w_take;

   assign w_stk_push = STACK_DEPTH'({r_ie_stk, 1'b0});
   assign w_stk_pop  = r_ie_stk >> 1;

   // Pending: set on a rising edge wins over W1C and acknowledge clears.
   assign w_pend_clr = ((w_mtc0_wr && bus.rd == CP0_CAUSE) ? bus.wdata[CA_PEND_LSB +: N_IRQ] : '0)
                     | (w_int_take ? w_irq_onehot : '0);
   assign w_pend_nxt = (r_pending & ~w_pend_clr) | w_rise;

   // Exception code of the winning source.
   always_comb begin
      if (w_unimpl) begin
         w_exccode = EXC_UNIMPL;
      end else if (w_sys) begin
         w_exccode = EXC_SYS;
      end else if (w_ov) begin
         w_exccode = EXC_OV;
      end else begin
         w_exccode = EXC_INT;
      end
   end

   // Architectural views of Status and Cause plus mfc0 mux.
   always_comb begin
      w_status = 32'd0;
      w_status[3:1] = r_en;
      w_status[ST_MASK_LSB +: N_IRQ] = r_mask;
      w_status[ST_IE_LSB +: STACK_DEPTH] = r_ie_stk;
      w_cause = 32'd0;
      w_cause[CA_EXC_LSB +: 4] = r_exccode;
      w_cause[CA_PEND_LSB +: N_IRQ] = r_pending;
      w_cause[CA_IDX_LSB +: IDX_W] = r_irq_idx;
      case (bus.rd)
         CP0_STATUS: w_rdata = w_status;
         CP0_CAUSE:  w_rdata = w_cause;
         CP0_EPC:    w_rdata = r_epc;
         default:    w_rdata = 32'd0;
      endcase
   end

   assign bus.rdata = bus.i_mfc0 ? w_rdata : 32'd0;
   assign bus.exc   = w_take;
   assign bus.selpc = w_take ? SELPC_HANDLER : (bus.i_eret ? SELPC_EPC : SELPC_SEQ);
   assign bus.inta  = w_int_take ? w_irq_onehot : '0;
   assign bus.epc   = r_epc;

   // State update: take beats eret beats mtc0; a dropped mtc0 never reaches the registers.
   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_en      <= 3'd0;
         r_mask    <= '0;
         r_ie_stk  <= '0;
         r_exccode <= 4'd0;
         r_irq_idx <= '0;
         r_epc     <= 32'd0;
      end else begin
         r_irq_q   <= bus.irq;
         r_pending <= w_pend_nxt;
         if (w_take) begin
            r_exccode <= w_exccode;
            r_epc     <= (w_exccode == EXC_SYS) ? pc_plus4(bus.pc) : bus.pc;
            r_ie_stk  <= w_stk_push;
            if (w_int_take) begin
               r_irq_idx <= w_irq_idx;
            end else begin
               r_irq_idx <= r_irq_idx;
            end
         end else if (bus.i_eret) begin
            r_ie_stk <= w_stk_pop;
         end else if (w_mtc0_wr && bus.rd == CP0_STATUS) begin
            r_en     <= bus.wdata[3:1];
            r_mask   <= bus.wdata[ST_MASK_LSB +: N_IRQ];
            r_ie_stk <= bus.wdata[ST_IE_LSB +: STACK_DEPTH];
         end else if (w_mtc0_wr && bus.rd == CP0_EPC) begin
            r_epc <= bus.wdata;
         end else begin
            r_epc <= r_epc;
         end
      end
   end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed scoreboard bench for cp0_irq_ctrl (N_IRQ=4, STACK_DEPTH=3).
module tb_cp0_irq_ctrl;

   logic clk;
   logic clrn;

   cp0_irq_ctrl_if #(.N_IRQ(4)) bus ();

   cp0_irq_ctrl #(.N_IRQ(4), .STACK_DEPTH(3)) dut (
      .Clk  (clk),
      .Clrn (clrn),
      .bus  (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty: observed %h with no expectation queued", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk_out(input string t, input logic e_exc, input logic [1:0] e_sel,
                          input logic [3:0] e_inta);
      push({t, "_exc"}, {31'd0, e_exc});
      push({t, "_selpc"}, {30'd0, e_sel});
      push({t, "_inta"}, {28'd0, e_inta});
      #1;
      pop_cmp({31'd0, bus.exc});
      pop_cmp({30'd0, bus.selpc});
      pop_cmp({28'd0, bus.inta});
   endtask

   task automatic rd_reg(input logic [4:0] r);
      bus.i_mfc0 = 1'b1;
      bus.rd     = r;
      #1;
      pop_cmp(bus.rdata);
      bus.i_mfc0 = 1'b0;
      bus.rd     = 5'd0;
   endtask

   task automatic chk_regs(input string t, input logic [31:0] st, input logic [31:0] ca,
                           input logic [31:0] ep);
      push({t, "_status"}, st);
      push({t, "_cause"}, ca);
      push({t, "_epc"}, ep);
      rd_reg(5'd12);
      rd_reg(5'd13);
      rd_reg(5'd14);
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      bus.i_mtc0 = 1'b1;
      bus.rd     = r;
      bus.wdata  = d;
      tick();
      bus.i_mtc0 = 1'b0;
      bus.rd     = 5'd0;
      bus.wdata  = 32'd0;
   endtask

   task automatic idle();
      bus.i_syscall = 1'b0;
      bus.i_unimpl  = 1'b0;
      bus.ov_event  = 1'b0;
      bus.i_mtc0    = 1'b0;
      bus.i_mfc0    = 1'b0;
      bus.i_eret    = 1'b0;
      bus.rd        = 5'd0;
      bus.wdata     = 32'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clrn    = 1'b0;
      bus.irq = 4'd0;
      bus.pc  = 32'd0;
      idle();
      tick();
      tick();
      clrn = 1'b1;
      chk_out("rst", 1'b0, 2'b00, 4'b0000);
      chk_regs("rst", 32'h0, 32'h0, 32'h0);

      // Single edge-triggered interrupt on line 2.
      mtc0(5'd12, 32'h0001_0F00);
      chk_regs("st_wr", 32'h0001_0F00, 32'h0, 32'h0);
      bus.irq = 4'b0100;
      chk_out("irq2_pend", 1'b0, 2'b00, 4'b0000);
      tick();
      bus.pc = 32'h0000_0100;
      chk_out("irq2_take", 1'b1, 2'b10, 4'b0100);
      tick();
      chk_out("irq2_after", 1'b0, 2'b00, 4'b0000);
      chk_regs("irq2", 32'h0002_0F00, 32'h0002_0000, 32'h0000_0100);
      bus.rd = 5'd14;
      push("rdata_gate", 32'h0);
      #1;
      pop_cmp(bus.rdata);
      tick();
      tick();
      chk_regs("irq2_hold", 32'h0002_0F00, 32'h0002_0000, 32'h0000_0100);

      // Simultaneous edges on lines 1 and 3.
      bus.irq    = 4'b0000;
      bus.i_eret = 1'b1;
      chk_out("eret1", 1'b0, 2'b01, 4'b0000);
      tick();
      bus.i_eret = 1'b0;
      chk_regs("eret1", 32'h0001_0F00, 32'h0002_0000, 32'h0000_0100);
      bus.irq = 4'b1010;
      tick();
      bus.pc = 32'h0000_0200;
      chk_out("irq1_take", 1'b1, 2'b10, 4'b0010);
      tick();
      chk_regs("irq1", 32'h0002_0F00, 32'h0001_0800, 32'h0000_0200);
      bus.i_eret = 1'b1;
      chk_out("eret2", 1'b0, 2'b01, 4'b0000);
      tick();
      bus.i_eret = 1'b0;
      bus.pc = 32'h0000_0300;
      chk_out("irq3_take", 1'b1, 2'b10, 4'b1000);
      tick();
      bus.irq = 4'b0000;
      chk_regs("irq3", 32'h0002_0F00, 32'h0003_0000, 32'h0000_0300);

      // Syscall disabled then enabled.
      bus.i_syscall = 1'b1;
      bus.pc = 32'h0000_0040;
      chk_out("sys_off", 1'b0, 2'b00, 4'b0000);
      tick();
      bus.i_syscall = 1'b0;
      chk_regs("sys_off", 32'h0002_0F00, 32'h0003_0000, 32'h0000_0300);
      mtc0(5'd12, 32'h0001_0F02);
      bus.i_syscall = 1'b1;
      chk_out("sys_on", 1'b1, 2'b10, 4'b0000);
      tick();
      bus.i_syscall = 1'b0;
      chk_regs("sys_on", 32'h0002_0F02, 32'h0003_0004, 32'h0000_0044);

      // Overflow colliding with mtc0 Status: write is dropped.
      mtc0(5'd12, 32'h0001_0F08);
      bus.ov_event = 1'b1;
      bus.i_mtc0   = 1'b1;
      bus.rd       = 5'd12;
      bus.wdata    = 32'h0000_0000;
      bus.pc       = 32'h0000_0080;
      chk_out("ov_mtc0", 1'b1, 2'b10, 4'b0000);
      tick();
      idle();
      chk_regs("ov_mtc0", 32'h0002_0F08, 32'h0003_000C, 32'h0000_0080);

      // Unimplemented beats syscall; EPC is the faulting pc.
      mtc0(5'd12, 32'h0000_0F06);
      bus.i_unimpl  = 1'b1;
      bus.i_syscall = 1'b1;
      bus.pc        = 32'h0000_0090;
      chk_out("unimpl", 1'b1, 2'b10, 4'b0000);
      tick();
      idle();
      chk_regs("unimpl", 32'h0000_0F06, 32'h0003_0008, 32'h0000_0090);

      // W1C on Cause pending, and set-wins collision.
      mtc0(5'd12, 32'h0001_0000);
      bus.irq = 4'b0001;
      tick();
      chk_regs("pend0", 32'h0001_0000, 32'h0003_0108, 32'h0000_0090);
      mtc0(5'd13, 32'h0000_0100);
      chk_regs("w1c", 32'h0001_0000, 32'h0003_0008, 32'h0000_0090);
      mtc0(5'd12, 32'h0001_0100);
      chk_out("w1c_noirq", 1'b0, 2'b00, 4'b0000);
      bus.irq = 4'b0000;
      tick();
      mtc0(5'd12, 32'h0001_0000);
      bus.irq = 4'b0001;
      mtc0(5'd13, 32'h0000_0100);
      chk_regs("set_wins", 32'h0001_0000, 32'h0003_0108, 32'h0000_0090);

      // No interrupt in an eret cycle, then nesting through the IE stack.
      bus.irq = 4'b0000;
      mtc0(5'd12, 32'h0003_0300);
      bus.i_eret = 1'b1;
      chk_out("eret_block", 1'b0, 2'b01, 4'b0000);
      tick();
      bus.i_eret = 1'b0;
      bus.pc = 32'h0000_0500;
      chk_out("nest_irq0", 1'b1, 2'b10, 4'b0001);
      tick();
      chk_regs("nest_irq0", 32'h0002_0300, 32'h0000_0000, 32'h0000_0500);
      bus.irq = 4'b0010;
      mtc0(5'd12, 32'h0003_0300);
      bus.pc = 32'h0000_0600;
      chk_out("nest_irq1", 1'b1, 2'b10, 4'b0010);
      tick();
      chk_regs("nest_irq1", 32'h0006_0300, 32'h0001_0000, 32'h0000_0600);
      bus.i_eret = 1'b1;
      tick();
      bus.i_eret = 1'b0;
      chk_regs("pop1", 32'h0003_0300, 32'h0001_0000, 32'h0000_0600);
      bus.i_eret = 1'b1;
      tick();
      bus.i_eret = 1'b0;
      chk_regs("pop2", 32'h0001_0300, 32'h0001_0000, 32'h0000_0600);

      // Reset mid-handler clears everything; IE=0 blocks a new edge.
      clrn = 1'b0;
      tick();
      clrn = 1'b1;
      chk_regs("rst2", 32'h0, 32'h0, 32'h0);
      tick();
      chk_out("rst2_noirq", 1'b0, 2'b00, 4'b0000);
      chk_regs("rst2_pend", 32'h0, 32'h0000_0200, 32'h0);

      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: observed %0d entries required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
